apb_irq_ctrl: RTL

- APB-mapped interrupt controller that sits directly downstream of the timer peripheral.
- Collects timer_systick_irq, timer_hires_irq and other peripheral interrupt lines, and latches them as pending.
- Applies per-source enable masks and selects the lowest-index active source.
- Presents a single request plus ID to the nanorv32 core, which retires it through an ack handshake.

---
 rtl/intc_pkg.sv | 23 ++
 rtl/intc_src_cond.sv | 60 ++++++
 rtl/apb_irq_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
// Shared definitions for the APB interrupt controller.
// Holds the register word offsets, the request FSM encoding and default sizing.
package intc_pkg;

    // Default sizing: number of sources and width of the request ID.
    localparam int unsigned INTC_NB_IRQ = 8;
    localparam int unsigned INTC_IDW    = 4;

    // Register word index, i.e. paddr[4:2].
    localparam logic [2:0] REG_RAW       = 3'd0;  // 0x00
    localparam logic [2:0] REG_PENDING   = 3'd1;  // 0x04
    localparam logic [2:0] REG_ENABLE    = 3'd2;  // 0x08
    localparam logic [2:0] REG_EDGE_SEL  = 3'd3;  // 0x0C
    localparam logic [2:0] REG_ACTIVE_ID = 3'd4;  // 0x10

    // Request handshake states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } intc_state_e;

endpackage

// File: rtl/intc_src_cond.sv
// Per-source conditioning for the interrupt controller.
// Optional macro INTC_SYNC_EN inserts a 2-flop synchronizer per source line.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   src_i    : raw interrupt lines
//   cond_c   : conditioned lines (synchronized when INTC_SYNC_EN is defined)
//   rise_c   : one-cycle rising-edge pulse of cond_c
module intc_src_cond
    import intc_pkg::*;
#(
    parameter int unsigned NB_IRQ = INTC_NB_IRQ
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NB_IRQ-1:0] src_i,
    output logic [NB_IRQ-1:0] cond_c,
    output logic [NB_IRQ-1:0] rise_c
);

    logic [NB_IRQ-1:0] prev_d, prev_q;

`ifdef INTC_SYNC_EN
    logic [NB_IRQ-1:0] sync1_d, sync1_q, sync2_d, sync2_q;

    // Two-stage synchronizer for asynchronous sources.
    always_comb begin
        sync1_d = src_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign cond_c = sync2_q;
`else
    assign cond_c = src_i;
`endif

    // Previous-cycle copy for rising-edge detection.
    always_comb begin
        prev_d = cond_c;
        rise_c = cond_c & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB-mapped interrupt controller: latches pending sources, masks them, and
// presents the lowest-index active source to the core with an ack handshake.
// Optional macro INTC_SYNC_EN: synchronize irq_src before edge/level logic.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   irq_src             : raw interrupt lines (bit0 systick, bit1 hires timer)
//   apb_intc_*          : APB slave inputs; intc_apb_* : APB slave outputs
//   intc_cpu_irq/_id    : request and source index to the core
//   cpu_intc_irq_ack    : one-cycle acknowledge from the core
module apb_irq_ctrl
    import intc_pkg::*;
#(
    parameter int unsigned NB_IRQ = INTC_NB_IRQ,
    parameter int unsigned IDW    = INTC_IDW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NB_IRQ-1:0] irq_src,
    input  logic              apb_intc_psel,
    input  logic [11:0]       apb_intc_paddr,
    input  logic              apb_intc_penable,
    input  logic              apb_intc_pwrite,
    input  logic [31:0]       apb_intc_pwdata,
    output logic [31:0]       intc_apb_prdata,
    output logic              intc_apb_pready,
    output logic              intc_apb_pslverr,
    output logic              intc_cpu_irq,
    output logic [IDW-1:0]    intc_cpu_irq_id,
    input  logic              cpu_intc_irq_ack
);

    logic [NB_IRQ-1:0] cond, rise;
    logic [NB_IRQ-1:0] pending_d, pending_q;
    logic [NB_IRQ-1:0] enable_d, enable_q;
    logic [NB_IRQ-1:0] edge_sel_d, edge_sel_q;
    logic [NB_IRQ-1:0] w1c, ack_clr, masked, id_oh, wdata;
    logic [IDW-1:0]    id_d, id_q, sel_id;
    logic              irq_d, irq_q;
    logic              wr_en, rd_en;
    logic [2:0]        reg_sel;
    intc_state_e       state_d, state_q;
    logic              unused_apb;

    intc_src_cond #(.NB_IRQ(NB_IRQ)) u_src_cond (
        .clk    (clk),
        .rst    (rst),
        .src_i  (irq_src),
        .cond_c (cond),
        .rise_c (rise)
    );

    assign wr_en   = apb_intc_psel & apb_intc_penable & apb_intc_pwrite;
    assign rd_en   = apb_intc_psel & ~apb_intc_pwrite;
    assign reg_sel = apb_intc_paddr[4:2];
    assign wdata   = apb_intc_pwdata[NB_IRQ-1:0];
    assign unused_apb = ^{apb_intc_paddr[11:5], apb_intc_paddr[1:0],
                          apb_intc_pwdata[31:NB_IRQ]};

    assign intc_apb_pready  = 1'b1;
    assign intc_apb_pslverr = 1'b0;
    assign intc_cpu_irq     = irq_q;
    assign intc_cpu_irq_id  = id_q;

    // One-hot of the latched ID, and lowest-index selection of masked sources.
    always_comb begin
        masked = pending_q & enable_q;
        sel_id = '0;
        id_oh  = '0;
        for (int i = NB_IRQ - 1; i >= 0; i--) begin
            if (masked[i]) sel_id = IDW'(i);
        end
        for (int i = 0; i < NB_IRQ; i++) begin
            id_oh[i] = (id_q == IDW'(i));
        end
    end

    // Register writes and pending update; an edge set wins over any clear.
    always_comb begin
        enable_d   = enable_q;
        edge_sel_d = edge_sel_q;
        w1c        = '0;
        ack_clr    = '0;
        if (wr_en) begin
            case (reg_sel)
                REG_PENDING:  w1c        = wdata;
                REG_ENABLE:   enable_d   = wdata;
                REG_EDGE_SEL: edge_sel_d = wdata;
                default:      ;
            endcase
        end
        if (state_q == REQ && cpu_intc_irq_ack) ack_clr = id_oh;
        for (int i = 0; i < NB_IRQ; i++) begin
            if (edge_sel_q[i]) pending_d[i] = (pending_q[i] & ~w1c[i] & ~ack_clr[i]) | rise[i];
            else               pending_d[i] = cond[i];
        end
    end

    // Request FSM; a request is retracted when its enable bit is being cleared.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (|masked) begin
                    id_d    = sel_id;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (cpu_intc_irq_ack)             state_d = DONE;
                else if ((enable_d & id_oh) == '0) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        irq_d = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            enable_q   <= '0;
            edge_sel_q <= '0;
            state_q    <= IDLE;
            id_q       <= '0;
            irq_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            edge_sel_q <= edge_sel_d;
            state_q    <= state_d;
            id_q       <= id_d;
            irq_q      <= irq_d;
        end
    end

    // Combinational read mux; zero when not reading.
    always_comb begin
        intc_apb_prdata = '0;
        if (rd_en) begin
            case (reg_sel)
                REG_RAW:       intc_apb_prdata = 32'(cond);
                REG_PENDING:   intc_apb_prdata = 32'(pending_q);
                REG_ENABLE:    intc_apb_prdata = 32'(enable_q);
                REG_EDGE_SEL:  intc_apb_prdata = 32'(edge_sel_q);
                REG_ACTIVE_ID: intc_apb_prdata = {irq_q, 31'(id_q)};
                default:       intc_apb_prdata = '0;
            endcase
        end
    end

endmodule
